// File: rtl/dds_mod_ctrl.sv
// Quadrant sequencer and BPSK/OOK symbol controller for the dds_dp quarter-wave datapath.
// Tracks co6 carries to step P/S through a full sine period and applies modulation per symbol.
module dds_mod_ctrl #(
    parameter int CYC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [CYC_W-1:0] cycles_per_sym,
    input  logic             bit_valid,
    input  logic             bit_data,
    output logic             bit_ready,
    input  logic             co6,
    output logic             P,
    output logic             S,
    output logic             amp_en,
    output logic             sym_start,
    output logic             underrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [1:0]       MODE_CW   = 2'b00;
    localparam logic [1:0]       MODE_BPSK = 2'b01;
    localparam logic [1:0]       MODE_OOK  = 2'b10;
    localparam logic [CYC_W-1:0] CNT_ONE   = CYC_W'(1);
    localparam logic [CYC_W-1:0] CNT_ZERO  = CYC_W'(0);

    state_t           state_r, state_s;
    logic [1:0]       q_r, q_s;
    logic [CYC_W-1:0] per_cnt_r, per_cnt_s;
    logic [CYC_W-1:0] n_r, n_s;
    logic [1:0]       mode_r, mode_s;
    logic             cur_bit_r, cur_bit_s;
    logic             underrun_r, underrun_s;
    logic             sym_end_s, boundary_s, bit_ready_s;
    logic             p_s, s_s, amp_en_s;
    logic             p_r, s_r, amp_en_r, sym_start_r, busy_r;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; dropping en returns to IDLE from anywhere
    always_comb begin
        state_s = state_r;
        if (!en) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_s = ST_ARM;
                ST_ARM:  state_s = co6 ? ST_RUN : ST_ARM;
                ST_RUN:  state_s = ST_RUN;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // Symbol boundary detection: last address of the last quadrant of the last period, or ARM alignment
    always_comb begin
        sym_end_s  = (q_r == 2'd3) && (per_cnt_r == (n_r - CNT_ONE));
        boundary_s = rst && en && co6 &&
                     ((state_r == ST_ARM) || ((state_r == ST_RUN) && sym_end_s));
    end

    // Sequencing datapath: quadrant/period counters, symbol parameters and bit capture
    always_comb begin
        q_s         = q_r;
        per_cnt_s   = per_cnt_r;
        n_s         = n_r;
        mode_s      = mode_r;
        cur_bit_s   = cur_bit_r;
        underrun_s  = underrun_r;
        bit_ready_s = 1'b0;
        if (!en) begin
            q_s        = 2'd0;
            per_cnt_s  = CNT_ZERO;
            cur_bit_s  = 1'b0;
            underrun_s = 1'b0;
        end else if (boundary_s) begin
            q_s         = 2'd0;
            per_cnt_s   = CNT_ZERO;
            mode_s      = mode;
            n_s         = (cycles_per_sym == CNT_ZERO) ? CNT_ONE : cycles_per_sym;
            bit_ready_s = (mode == MODE_BPSK) || (mode == MODE_OOK);
            if (bit_ready_s && bit_valid) begin
                cur_bit_s = bit_data;
            end else if (bit_ready_s) begin
                cur_bit_s  = 1'b0;
                underrun_s = 1'b1;
            end else begin
                cur_bit_s = 1'b0;
            end
        end else if ((state_r == ST_RUN) && co6) begin
            q_s = q_r + 2'd1;
            if (q_r == 2'd3) begin
                per_cnt_s = per_cnt_r + CNT_ONE;
            end else begin
                per_cnt_s = per_cnt_r;
            end
        end else begin
            q_s = q_r;
        end
    end

    // Output decode from next-cycle values so P/S land together with the dds_dp address wrap
    always_comb begin
        p_s      = 1'b0;
        s_s      = 1'b0;
        amp_en_s = 1'b0;
        if (state_s == ST_RUN) begin
            p_s      = q_s[0];
            s_s      = q_s[1] ^ ((mode_s == MODE_BPSK) && cur_bit_s);
            amp_en_s = !((mode_s == MODE_OOK) && !cur_bit_s);
        end else begin
            p_s      = 1'b0;
            s_s      = 1'b0;
            amp_en_s = 1'b0;
        end
    end

    // Datapath and registered output state
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r         <= 2'd0;
            per_cnt_r   <= CNT_ZERO;
            n_r         <= CNT_ONE;
            mode_r      <= MODE_CW;
            cur_bit_r   <= 1'b0;
            underrun_r  <= 1'b0;
            p_r         <= 1'b0;
            s_r         <= 1'b0;
            amp_en_r    <= 1'b0;
            sym_start_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            q_r         <= q_s;
            per_cnt_r   <= per_cnt_s;
            n_r         <= n_s;
            mode_r      <= mode_s;
            cur_bit_r   <= cur_bit_s;
            underrun_r  <= underrun_s;
            p_r         <= p_s;
            s_r         <= s_s;
            amp_en_r    <= amp_en_s;
            sym_start_r <= boundary_s;
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign bit_ready = bit_ready_s;
    assign P         = p_r;
    assign S         = s_r;
    assign amp_en    = amp_en_r;
    assign sym_start = sym_start_r;
    assign underrun  = underrun_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dds_mod_ctrl.sv
// Scoreboard bench for dds_mod_ctrl: a symbol-time reference model predicts each cycle's outputs,
// a monitor process pops and compares them against the DUT.
module tb_dds_mod_ctrl;

    localparam int CYC_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic [CYC_W-1:0] cycles_per_sym;
    logic             bit_valid;
    logic             bit_data;
    logic             bit_ready;
    logic             co6;
    logic             P, S, amp_en, sym_start, underrun, busy;

    int checks   = 0;
    int failures = 0;

    logic       ready_q[$];
    logic [5:0] out_q[$];

    int addr       = 0;
    bit co6_jitter = 1'b0;

    // Reference model: position measured in clocks since the start of the current symbol
    int m_phase = 0;    // 0 idle, 1 waiting for alignment, 2 running
    int m_t     = 0;
    int m_mode  = 0;
    int m_n     = 1;
    bit m_bit   = 1'b0;
    bit m_under = 1'b0;

    dds_mod_ctrl #(.CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .cycles_per_sym(cycles_per_sym),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready), .co6(co6),
        .P(P), .S(S), .amp_en(amp_en), .sym_start(sym_start), .underrun(underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit bnd, rdy, needs, pe, se, ae;
        int quad;
        bnd = 1'b0;
        rdy = 1'b0;
        if (!rst) begin
            m_phase = 0; m_t = 0; m_mode = 0; m_n = 1; m_bit = 1'b0; m_under = 1'b0;
        end else if (!en) begin
            m_phase = 0; m_t = 0; m_bit = 1'b0; m_under = 1'b0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else begin
            if (m_phase == 1) bnd = co6;
            else              bnd = (m_t == m_n * 256 - 1);
            if (bnd) begin
                m_mode = int'(mode);
                m_n    = (cycles_per_sym == 0) ? 1 : int'(cycles_per_sym);
                needs  = (m_mode == 1) || (m_mode == 2);
                rdy    = needs;
                m_bit  = needs && bit_valid && bit_data;
                if (needs && !bit_valid) m_under = 1'b1;
                m_t     = 0;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_t = m_t + 1;
            end
        end
        quad = (m_t / 64) % 4;
        pe = 1'b0; se = 1'b0; ae = 1'b0;
        if (m_phase == 2) begin
            pe = quad[0];
            se = quad[1] ^ ((m_mode == 1) && m_bit);
            ae = !((m_mode == 2) && !m_bit);
        end
        ready_q.push_back(rdy);
        out_q.push_back({pe, se, ae, bnd, m_under, m_phase != 0});
    endtask

    // One clock of stimulus: inputs already set by the caller are scored, then time advances
    task automatic step();
        co6 = co6_jitter ? 1'($urandom_range(1, 0)) : (addr == 63);
        model_step();
        @(posedge clk);
        #2;
        addr = (addr + 1) % 64;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: bit_ready checked mid-cycle, registered outputs just after the edge
    initial begin
        logic       r;
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (ready_q.size() > 0) begin
                r = ready_q.pop_front();
                checks++;
                if (bit_ready !== r) begin
                    failures++;
                    $display("FAIL bit_ready t=%0t got=%b exp=%b", $time, bit_ready, r);
                end
            end
            @(posedge clk);
            #1;
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                checks++;
                if ({P, S, amp_en, sym_start, underrun, busy} !== e) begin
                    failures++;
                    $display("FAIL outputs(P,S,amp,sym,under,busy) t=%0t got=%b exp=%b",
                             $time, {P, S, amp_en, sym_start, underrun, busy}, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; en = 1'b1; mode = 2'b00; cycles_per_sym = 4'd0;
        bit_valid = 1'b0; bit_data = 1'b0; co6 = 1'b0;
        @(posedge clk);
        #2;
        // reset with co6 toggling
        co6_jitter = 1'b1;
        run(3);
        co6_jitter = 1'b0;
        rst = 1'b1;
        // CW with N=0
        run(700);
        // BPSK N=1, bits 1 then 0
        mode = 2'b01; cycles_per_sym = 4'd1; bit_valid = 1'b1; bit_data = 1'b1;
        run(300);
        bit_data = 1'b0;
        run(300);
        // OOK N=2, bits 0 then 1
        mode = 2'b10; cycles_per_sym = 4'd2; bit_data = 1'b0;
        run(600);
        bit_data = 1'b1;
        run(600);
        // underrun then recovery via en toggle
        mode = 2'b01; cycles_per_sym = 4'd1; bit_valid = 1'b0;
        run(300);
        bit_valid = 1'b1;
        run(300);
        en = 1'b0;
        run(2);
        en = 1'b1;
        run(400);
        // abort mid-symbol and realign
        run(100);
        en = 1'b0;
        run(1);
        en = 1'b1;
        run(300);
        // randomized traffic including reserved mode and mid-symbol parameter changes
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(199, 0) == 0) mode = 2'($urandom_range(3, 0));
            if ($urandom_range(199, 0) == 0) cycles_per_sym = 4'($urandom_range(3, 0));
            bit_valid = ($urandom_range(9, 0) != 0);
            bit_data  = 1'($urandom_range(1, 0));
            if ($urandom_range(999, 0) == 0)            en = 1'b0;
            else if (!en && $urandom_range(3, 0) == 0)  en = 1'b1;
            rst = ($urandom_range(4999, 0) != 0);
            step();
        end
        rst = 1'b1;
        for (int i = 0; i < 10 && (out_q.size() > 0 || ready_q.size() > 0); i++) @(posedge clk);
        #3;
        checks++;
        if (out_q.size() != 0 || ready_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", out_q.size() + ready_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dds_mod_ctrl.md
# dds_mod_ctrl

Sequencing controller for the `dds_dp` direct-digital-synthesis datapath. It tracks the datapath's 64-step address sweep via `co6` and drives the quadrant controls `P` (mirror) and `S` (sign) to build a full 256-clock sine period from the quarter-wave ROM. It also runs a symbol timer and a valid/ready bit interface that applies BPSK (sign inversion) or OOK (amplitude gate) modulation at symbol boundaries. It sits between the bit source and `dds_dp` in the digital modulation top level.

## Interface

Parameters:
- `CYC_W`, default 4: width of the sine-periods-per-symbol field.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset; shared with `dds_dp`.
- `en` in 1: run enable; low forces IDLE.
- `mode` in 2: modulation mode.
  - 00 = CW, 01 = BPSK, 10 = OOK.
  - 11 is reserved and treated as CW.
- `cycles_per_sym` in CYC_W: sine periods per symbol; 0 is treated as 1.
- `bit_valid` in 1: source has a data bit.
- `bit_data` in 1: data bit.
- `bit_ready` out 1: controller accepts the bit this cycle.
- `co6` in 1: `dds_dp` address carry, high in the cycle the address is 63.
- `P` out 1: to `dds_dp` P (address mirror).
- `S` out 1: to `dds_dp` S (output negate).
- `amp_en` out 1: downstream amplitude gate; 0 forces the output to zero.
- `sym_start` out 1: one-cycle pulse in the first cycle of each symbol.
- `underrun` out 1: sticky flag; a symbol boundary passed with no valid bit.
- `busy` out 1: state is not IDLE.

## Operation

- States:
  - IDLE: waits for `en`.
  - ARM: waits for `co6` to align to address 0.
  - RUN: active.
- Transitions:
  - IDLE→ARM when `en`=1.
  - ARM→RUN on the edge where `co6`=1.
  - Any state→IDLE on the next edge when `en`=0.
  - `rst`=0 overrides everything.
- Registers:
  - `q[1:0]`: quadrant index.
  - `per_cnt[CYC_W-1:0]`: period counter.
  - `cur_bit`: current symbol's data bit.
  - `mode_r`, `n_r`: latched mode and periods-per-symbol.
- In RUN, on each edge with `co6`=1, `q` increments (wraps 3→0).
  - When `q`=3 wraps, `per_cnt` increments.
- Symbol boundary: `co6`=1 & `q`=3 & `per_cnt`=`n_r`-1, or `co6`=1 in ARM. At the boundary:
  - `q` and `per_cnt` go to 0.
  - `mode_r` and `n_r` are reloaded from the ports.
  - `cur_bit` is loaded.
  - `sym_start` pulses the next cycle.
- `bit_ready` is combinational. It equals boundary & (new mode is BPSK or OOK).
- Bit transfer occurs on `bit_valid` & `bit_ready`; `cur_bit` <= `bit_data`.
  - If `bit_ready`=1 but `bit_valid`=0: `cur_bit` <= 0 and `underrun` <= 1.
  - In CW, no bit is consumed and `cur_bit` <= 0.
- `underrun` clears only on `rst`=0 or on entry to IDLE.
- Outputs in RUN:
  - `P` = `q[0]`.
  - `S` = `q[1]` XOR (`mode_r`=BPSK & `cur_bit`).
  - `amp_en` = NOT (`mode_r`=OOK & !`cur_bit`).
- Outputs in IDLE/ARM: `P`=`S`=`amp_en`=0.
- Mode and `cycles_per_sym` changes mid-symbol have no effect until the next boundary.

## Timing

- Reset (`rst`=0 at an edge): state=IDLE, `q`=0, `per_cnt`=0, `cur_bit`=0, `underrun`=0. All outputs are 0.
- All outputs except `bit_ready` are registered.
  - `P`/`S` change in the same cycle as the `dds_dp` address wrap 63→0, so the new quadrant starts at address 0.
- Full sine period = 256 clocks. Symbol = `n_r`×256 clocks.
- Latency from ARM seeing `co6` to first RUN output: 1 clock.
- `bit_data` is sampled only in boundary cycles. It is ignored at all other times, regardless of `bit_valid`.
- `en`=0 mid-symbol: the symbol is abandoned and IDLE outputs apply next cycle.
  - Re-enabling always passes through ARM, which realigns to `co6`.
- `rst`=0 mid-operation behaves like reset, regardless of `en`.
- `co6` in IDLE is ignored.
- Boundary with `en`=0 in the same cycle: IDLE wins; no bit is consumed and `bit_ready`=0.

## Test plan

- **Reset:** hold `rst`=0 for 3 clocks with `en`=1 and `co6` toggling → all outputs 0, `busy`=0. Release → ARM on the next edge.
- **CW:** `mode`=00, `en`=1, `co6` every 64 clocks → after the first `co6`, (`P`,`S`) steps through 00, 10, 01, 11, each phase 64 clocks. `amp_en`=1, `bit_ready` never 1, `sym_start` every 256 clocks (N=0→1).
- **BPSK:** `mode`=01, N=1, bits 1,0 held valid → `bit_ready` pulses at each boundary `co6`.
  - First 256 clocks: (`P`,`S`) = 01, 11, 00, 10.
  - Next 256 clocks: 00, 10, 01, 11.
- **OOK:** `mode`=10, N=2, bits 0,1 → `amp_en`=0 for 512 clocks, then 1 for 512 clocks. `sym_start` pulses at 0 and 512.
- **Underrun:** BPSK, `bit_valid`=0 at the second boundary → `underrun`=1 and stays 1, second symbol uses `cur_bit`=0. Restoring `bit_valid` does not clear the flag; `en`=0 then 1 clears it.
- **Abort/realign:** `en`=0 at clock 100 of a symbol → next cycle `P`=`S`=`amp_en`=`busy`=0. `en`=1 at an address ≠63 → stays in ARM (outputs 0) until the next `co6`, then restarts at `q`=0.
